// File: rtl/mmu_fetch_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, kseg regions, address translation.
package mmu_fetch_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    I_REQ,
    I_WAIT,
    I_DONE
  } state_t;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else is identity.
  function automatic logic [31:0] xlate_addr(input logic [31:0] vaddr);
    if (vaddr[31:29] == KSEG0 || vaddr[31:29] == KSEG1) begin
      return {3'b000, vaddr[28:0]};
    end
    return vaddr;
  endfunction

endpackage

// File: rtl/mmu_addr_xlate.sv
// Combinational virtual-to-physical translation with kseg1 uncached flag.
module mmu_addr_xlate
  import mmu_fetch_arbiter_pkg::*;
(
  input  logic [31:0] vaddr,
  output logic [31:0] paddr,
  output logic        uncached
);

  assign paddr    = xlate_addr(vaddr);
  assign uncached = (vaddr[31:29] == KSEG1);

endmodule

// File: rtl/mmu_fetch_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one memory port, one transaction outstanding.
// Data wins ties; a fetch is split into per-word requests and never crosses a line boundary.
module mmu_fetch_arbiter
  import mmu_fetch_arbiter_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int LINE_WORDS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_en,
  input  logic [31:0]               inst_addr,
  output logic                      inst_ok,
  output logic [FETCH_WIDTH-1:0]    inst_valid,
  output logic [32*FETCH_WIDTH-1:0] inst_data,
  input  logic                      data_en,
  input  logic [3:0]                data_wen,
  input  logic [31:0]               data_addr,
  input  logic [31:0]               data_wdata,
  output logic                      data_ok,
  output logic [31:0]               data_data,
  output logic                      mem_req,
  output logic [3:0]                mem_wen,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_uncached,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata
);

  localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  state_t                 state;
  logic [2:0]             cnt;
  logic [2:0]             n_words;
  logic                   inst_blk;
  logic                   data_blk;
  logic [31:0]            inst_blk_addr;
  logic [31:0]            data_blk_addr;
  logic [31:0]            vaddr;
  logic [2:0]             n_calc;
  logic [FETCH_WIDTH-1:0] mask;
  logic                   inst_go;
  logic                   data_go;
  int                     idx;
  int                     rem;

  always_comb begin
    idx    = (LINE_WORDS > 1) ? int'(inst_addr[IDX_W+1:2]) : 0;
    rem    = LINE_WORDS - idx;
    n_calc = (rem < FETCH_WIDTH) ? 3'(rem) : 3'(FETCH_WIDTH);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask[i] = (i < int'(n_words));
    end
    vaddr = (state == D_REQ) ? data_addr : inst_addr + {27'd0, cnt, 2'b00};
  end

  // A request already answered stays blocked until dropped or replaced by a new address.
  assign data_go = data_en && !(data_blk && data_addr == data_blk_addr);
  assign inst_go = inst_en && !(inst_blk && inst_addr == inst_blk_addr);

  mmu_addr_xlate u_xlate (
    .vaddr    (vaddr),
    .paddr    (mem_addr),
    .uncached (mem_uncached)
  );

  assign mem_wen   = (state == D_REQ) ? data_wen : 4'h0;
  assign mem_wdata = data_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      inst_ok       <= 1'b0;
      data_ok       <= 1'b0;
      inst_valid    <= '0;
      inst_data     <= '0;
      data_data     <= '0;
      cnt           <= '0;
      n_words       <= '0;
      inst_blk      <= 1'b0;
      data_blk      <= 1'b0;
      inst_blk_addr <= '0;
      data_blk_addr <= '0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      if (!data_en) data_blk <= 1'b0;
      if (!inst_en) inst_blk <= 1'b0;
      case (state)
        IDLE: begin
          if (data_go) begin
            state   <= D_REQ;
            mem_req <= 1'b1;
          end else if (inst_go) begin
            cnt       <= '0;
            inst_data <= '0;
            if (inst_addr[1:0] != 2'b00) begin
              n_words       <= '0;
              inst_valid    <= '0;
              inst_ok       <= 1'b1;
              inst_blk      <= 1'b1;
              inst_blk_addr <= inst_addr;
              state         <= I_DONE;
            end else begin
              n_words <= n_calc;
              mem_req <= 1'b1;
              state   <= I_REQ;
            end
          end
        end
        D_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (mem_rvalid) begin
            data_ok       <= 1'b1;
            data_data     <= mem_rdata;
            data_blk      <= 1'b1;
            data_blk_addr <= data_addr;
            state         <= IDLE;
          end
        end
        I_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= I_WAIT;
          end
        end
        I_WAIT: begin
          if (mem_rvalid) begin
            inst_data[int'(cnt)*32 +: 32] <= mem_rdata;
            if (cnt == n_words - 3'd1) begin
              inst_ok       <= 1'b1;
              inst_valid    <= mask;
              inst_blk      <= 1'b1;
              inst_blk_addr <= inst_addr;
              state         <= I_DONE;
            end else begin
              cnt     <= cnt + 3'd1;
              mem_req <= 1'b1;
              state   <= I_REQ;
            end
          end
        end
        I_DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_fetch_arbiter.sv
// Scoreboard bench for mmu_fetch_arbiter: directed requests, reactive memory model, decoupled monitor.
module tb_mmu_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ok;
  logic [1:0]  inst_valid;
  logic [63:0] inst_data;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ok;
  logic [31:0] data_data;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_uncached;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mmu_fetch_arbiter #(.FETCH_WIDTH(2), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_ok(inst_ok),
    .inst_valid(inst_valid), .inst_data(inst_data),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ok(data_ok), .data_data(data_data),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_uncached(mem_uncached),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] wen; logic unc; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic care; logic [31:0] d; } dat_exp_t;
  typedef struct { logic [1:0] valid; logic [63:0] data; } inst_exp_t;

  mem_exp_t  exp_mem[$];
  dat_exp_t  exp_dat[$];
  inst_exp_t exp_inst[$];

  int vectors = 0;
  int miscompares = 0;
  int ok_pulses = 0;
  bit hold = 1'b0;
  bit stray = 1'b0;
  bit rv_next = 1'b0;
  logic [31:0] rv_data = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: grants any request in the cycle it is seen, responds the following cycle.
  always @(posedge clk) begin
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      stray      = 1'b0;
    end else if (rv_next) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rv_data;
      rv_next    = 1'b0;
    end
    if (mem_req && !rst) begin
      mem_gnt = 1'b1;
      vectors++;
      if (exp_mem.size() == 0) begin
        miscompares++;
        $display("FAIL mem_req: unexpected request addr %h wen %h", mem_addr, mem_wen);
      end else begin
        mem_exp_t e;
        e = exp_mem.pop_front();
        if (mem_addr !== e.addr || mem_wen !== e.wen || mem_uncached !== e.unc ||
            (e.wen != 4'h0 && mem_wdata !== e.wdata)) begin
          miscompares++;
          $display("FAIL mem_req: got addr %h wen %h unc %b wdata %h expected addr %h wen %h unc %b wdata %h",
                   mem_addr, mem_wen, mem_uncached, mem_wdata, e.addr, e.wen, e.unc, e.wdata);
        end
      end
      if (!hold) begin
        rv_next = 1'b1;
        rv_data = mem_val(mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (data_ok) begin
        ok_pulses++;
        vectors++;
        if (exp_dat.size() == 0) begin
          miscompares++;
          $display("FAIL data_ok: unexpected pulse data %h", data_data);
        end else begin
          dat_exp_t d;
          d = exp_dat.pop_front();
          if (d.care && data_data !== d.d) begin
            miscompares++;
            $display("FAIL data_ok: got data %h expected %h", data_data, d.d);
          end
        end
      end
      if (inst_ok) begin
        ok_pulses++;
        vectors++;
        if (exp_inst.size() == 0) begin
          miscompares++;
          $display("FAIL inst_ok: unexpected pulse valid %b", inst_valid);
        end else begin
          inst_exp_t e;
          bit bad;
          e = exp_inst.pop_front();
          bad = (inst_valid !== e.valid);
          for (int i = 0; i < 2; i++) begin
            if (e.valid[i] && inst_data[32*i +: 32] !== e.data[32*i +: 32]) bad = 1'b1;
          end
          if (bad) begin
            miscompares++;
            $display("FAIL inst_ok: got valid %b data %h expected valid %b data %h",
                     inst_valid, inst_data, e.valid, e.data);
          end
        end
      end
    end
  end

  task automatic wait_data_ok();
    int n = 0;
    do begin @(negedge clk); n++; end while (!data_ok && n < 100);
    if (!data_ok) check("data_ok_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_inst_ok(output int lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!inst_ok && n < 100);
    lat = n;
    if (!inst_ok) check("inst_ok_timeout", 64'd0, 64'd1);
  endtask

  task automatic data_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd, input int extra);
    @(posedge clk); #1;
    data_en = 1'b1; data_addr = a; data_wen = w; data_wdata = wd;
    wait_data_ok();
    repeat (extra) @(posedge clk);
    @(posedge clk); #1;
    data_en = 1'b0;
  endtask

  task automatic inst_req(input logic [31:0] a, output int lat);
    @(posedge clk); #1;
    inst_en = 1'b1; inst_addr = a;
    wait_inst_ok(lat);
    @(posedge clk); #1;
    inst_en = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int ok_before;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_inst_ok", 64'(inst_ok), 64'd0);
    check("rst_data_ok", 64'(data_ok), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_data", inst_data, 64'd0);
    check("rst_data_data", 64'(data_data), 64'd0);
    rst = 1'b0;

    // kseg0 data read
    exp_mem.push_back('{32'h0000_0010, 4'h0, 1'b0, 32'h0});
    exp_dat.push_back('{1'b1, 32'hDEAD_BEEF});
    data_req(32'h8000_0010, 4'h0, 32'h0, 0);

    // kseg1 boot fetch, two words
    exp_mem.push_back('{32'h1FC0_0000, 4'h0, 1'b1, 32'h0});
    exp_mem.push_back('{32'h1FC0_0004, 4'h0, 1'b1, 32'h0});
    exp_inst.push_back('{2'b11, 64'h459A5A5E_459A5A5A});
    inst_req(32'hBFC0_0000, lat);

    // last word of a line: single-word fetch
    exp_mem.push_back('{32'h0000_001C, 4'h0, 1'b0, 32'h0});
    exp_inst.push_back('{2'b01, 64'h00000000_5A5A5A46});
    inst_req(32'h8000_001C, lat);

    // simultaneous write and fetch: write goes first
    exp_mem.push_back('{32'h0000_0040, 4'hF, 1'b0, 32'h1234_5678});
    exp_mem.push_back('{32'h0000_0100, 4'h0, 1'b0, 32'h0});
    exp_mem.push_back('{32'h0000_0104, 4'h0, 1'b0, 32'h0});
    exp_dat.push_back('{1'b0, 32'h0});
    exp_inst.push_back('{2'b11, 64'h5A5A5B5E_5A5A5B5A});
    @(posedge clk); #1;
    data_en = 1'b1; data_addr = 32'h0000_0040; data_wen = 4'hF; data_wdata = 32'h1234_5678;
    inst_en = 1'b1; inst_addr = 32'h0000_0100;
    wait_data_ok();
    @(posedge clk); #1;
    data_en = 1'b0; data_wen = 4'h0;
    wait_inst_ok(lat);
    @(posedge clk); #1;
    inst_en = 1'b0;

    // misaligned fetch: no memory traffic, empty mask
    exp_inst.push_back('{2'b00, 64'h0});
    inst_req(32'h8000_0002, lat);
    check("misaligned_latency_le2", 64'(lat <= 2), 64'd1);

    // reset while waiting for a fetch response
    exp_mem.push_back('{32'h0000_0000, 4'h0, 1'b0, 32'h0});
    hold = 1'b1;
    @(posedge clk); #1;
    inst_en = 1'b1; inst_addr = 32'h8000_0000;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_gnt && n < 100);
    if (!mem_gnt) check("gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; inst_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_mem_req", 64'(mem_req), 64'd0);
    ok_before = ok_pulses;
    @(negedge clk);
    stray = 1'b1;
    repeat (5) @(posedge clk);
    check("stray_rvalid_no_ok", 64'(ok_pulses - ok_before), 64'd0);
    hold = 1'b0;

    // kseg1 data read held past its ok: exactly one transaction
    exp_mem.push_back('{32'h0000_0020, 4'h0, 1'b1, 32'h0});
    exp_dat.push_back('{1'b1, 32'h5A5A_5A7A});
    data_req(32'hA000_0020, 4'h0, 32'h0, 3);

    repeat (5) @(posedge clk);
    check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
    check("dat_queue_empty", 64'(exp_dat.size()), 64'd0);
    check("inst_queue_empty", 64'(exp_inst.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmu_fetch_arbiter.md
MMU_FETCH_ARBITER -- requirements
Module: mmu_fetch_arbiter

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, number of 32-bit instruction words per fetch (legal 1..4).
REQ-002 Parameter LINE_WORDS, default 8, fetch-line size in words (power of 2, >= FETCH_WIDTH); a fetch never crosses a line boundary.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- inst_en, in, 1, fetch request, held high until inst_ok.
- inst_addr, in, 32, virtual fetch address, held while inst_en.
- inst_ok, out, 1, one-cycle fetch-complete pulse.
- inst_valid, out, FETCH_WIDTH, per-word valid mask, meaningful with inst_ok.
- inst_data, out, 32*FETCH_WIDTH, word i at bits [32i+31:32i].
- data_en, in, 1, data request, held until data_ok.
- data_wen, in, 4, byte write enables; 0 means read.
- data_addr, in, 32, virtual data address.
- data_wdata, in, 32, write data.
- data_ok, out, 1, one-cycle data-complete pulse.
- data_data, out, 32, read data, valid with data_ok.
- mem_req, out, 1, memory request, held until mem_gnt.
- mem_wen, out, 4, byte enables to memory.
- mem_addr, out, 32, physical word address.
- mem_wdata, out, 32, write data to memory.
- mem_uncached, out, 1, high for kseg1 accesses.
- mem_gnt, in, 1, request accepted this cycle.
- mem_rvalid, in, 1, response valid (reads and writes).
- mem_rdata, in, 32, read data.

Function
REQ-004 Translation: vaddr[31:29] of 3'b100 or 3'b101 maps to {3'b000, vaddr[28:0]}; all other addresses pass unchanged; mem_uncached = (vaddr[31:29] == 3'b101).
REQ-005 FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, I_DONE; at most one memory transaction outstanding.
REQ-006 IDLE: if data_en, go to D_REQ; else if inst_en, go to I_REQ; data wins on a simultaneous request.
REQ-007 D_REQ: assert mem_req carrying the translated data_addr, data_wen and data_wdata; on mem_gnt, go to D_WAIT.
REQ-008 D_WAIT: on mem_rvalid, pulse data_ok with data_data = mem_rdata (don't-care for writes) in the same cycle, then go to IDLE.
REQ-009 Fetch count N = min(FETCH_WIDTH, LINE_WORDS - word index of inst_addr within its line); words are fetched at consecutive word addresses.
REQ-010 I_REQ/I_WAIT: loop N times, one mem_req with mem_wen = 0 per word, capturing each mem_rdata into slot i; after the last rvalid, go to I_DONE.
REQ-011 I_DONE: pulse inst_ok for one cycle with inst_valid bits [N-1:0] set, then return to IDLE.
REQ-012 Misaligned fetch (inst_addr[1:0] != 0): no memory access; inst_ok pulses the cycle after IDLE accepts the request, with inst_valid = 0.
REQ-013 A fetch in progress is never preempted; a pending data_en is served next.
REQ-014 mem_req is deasserted in the cycle after mem_gnt; mem_rvalid outside D_WAIT/I_WAIT is ignored.
REQ-015 Back-to-back: a request held after its ok is not re-served until it is deasserted for at least one cycle, or a new request is presented in a later cycle (one ok per request).

Reset
REQ-016 Reset drives state to IDLE and sets mem_req, inst_ok, data_ok, inst_valid, inst_data, data_data and the word counter to 0.
REQ-017 Reset mid-transaction abandons the transaction; the memory side is reset together with this block.

Structure
REQ-018 A shared package holds the FSM state enum, the kseg region constants and the translation function.
REQ-019 One sub-module, mmu_addr_xlate (combinational translation), is instantiated once on the muxed address.

Verification
REQ-020 Data read to 0x8000_0010 with gnt/rvalid next cycle and rdata 0xDEAD_BEEF -> mem_addr 0x0000_0010, mem_uncached 0, data_ok with data_data 0xDEAD_BEEF.
REQ-021 Fetch at 0xBFC0_0000, FETCH_WIDTH 2 -> requests to 0x1FC0_0000 and 0x1FC0_0004, mem_uncached 1, inst_ok with inst_valid 2'b11.
REQ-022 Fetch at 0x8000_001C, LINE_WORDS 8 -> exactly one memory request, inst_valid 2'b01.
REQ-023 inst_en and data_en (write 0x1234_5678, wen 4'hF) raised in the same cycle -> write issued first, data_ok, then the fetch.
REQ-024 Fetch at 0x8000_0002 -> no mem_req; inst_ok with inst_valid 0 within 2 cycles.
REQ-025 rst asserted in I_WAIT -> next cycle mem_req 0 and state IDLE; a later rvalid produces no ok pulse.
